// File: rtl/adder_subtractor_4b_pkg.sv
// Shared constants for the adder/subtractor slice: mode encodings and default width.
package add_sub_pkg;
  localparam int unsigned DEF_WIDTH = 4;
  localparam logic        ADD       = 1'b0;
  localparam logic        SUB       = 1'b1;
endpackage

// File: rtl/adder_subtractor_4b_if.sv
// Operand/result bundle for adder_subtractor_4b. ADD_SUB_FLAGS_EN adds overflow/zero.
interface adder_subtractor_4b_if import add_sub_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH
) ();
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             in_valid;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             out_valid;
`ifdef ADD_SUB_FLAGS_EN
  logic             overflow;
  logic             zero;
`endif

  modport master (
    output a, b, cin, in_valid,
`ifdef ADD_SUB_FLAGS_EN
    input  overflow, zero,
`endif
    input  sum, cout, out_valid
  );

  modport slave (
    input  a, b, cin, in_valid,
`ifdef ADD_SUB_FLAGS_EN
    output overflow, zero,
`endif
    output sum, cout, out_valid
  );
endinterface

// File: rtl/adder_subtractor_4b_full_adder.sv
// One-bit full-adder cell; the ripple chain is built from WIDTH of these.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/adder_subtractor_4b.sv
// Registered ripple-carry adder/subtractor; cin selects add (0) or subtract (1).
// Optional overflow/zero flags when ADD_SUB_FLAGS_EN is defined.
module adder_subtractor_4b import add_sub_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  adder_subtractor_4b_if.slave  bus
);
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum_d, sum_q;
  logic             cout_d, cout_q;
  logic             vld_q;

  // Subtract is a + ~b + 1: the mode bit both inverts B and seeds the chain.
  assign b_eff    = bus.b ^ {WIDTH{bus.cin == SUB}};
  assign carry[0] = bus.cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_chain
    full_adder u_fa (
      .a    (bus.a[i]),
      .b    (b_eff[i]),
      .cin  (carry[i]),
      .s    (sum_d[i]),
      .cout (carry[i+1])
    );
  end

  assign cout_d = carry[WIDTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q  <= '0;
      cout_q <= 1'b0;
      vld_q  <= 1'b0;
    end else begin
      vld_q <= bus.in_valid;
      if (bus.in_valid) begin
        sum_q  <= sum_d;
        cout_q <= cout_d;
      end
    end
  end

  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
  assign bus.out_valid = vld_q;

`ifdef ADD_SUB_FLAGS_EN
  logic ovf_d, ovf_q, zero_d, zero_q;

  assign ovf_d  = carry[WIDTH] ^ carry[WIDTH-1];
  assign zero_d = (sum_d == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
    end else if (bus.in_valid) begin
      ovf_q  <= ovf_d;
      zero_q <= zero_d;
    end
  end

  assign bus.overflow = ovf_q;
  assign bus.zero     = zero_q;
`endif
endmodule

// File: tb/tb_adder_subtractor_4b.sv
// Self-checking bench for adder_subtractor_4b (WIDTH = 4), directed plus random stimulus.
module tb_adder_subtractor_4b;
  localparam int W = 4;

  logic clk = 1'b0;
  logic rst;
  int   nvec = 0;
  int   errs = 0;

  logic [W-1:0] e_sum;
  logic         e_cout, e_vld, e_ovf, e_zero;

  always #5 clk = ~clk;

  adder_subtractor_4b_if #(.WIDTH(W)) bus ();

  adder_subtractor_4b #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Reference: plain integer arithmetic on the unsigned and signed views.
  function automatic void ref_op(input int ua, input int ub, input logic sub,
                                 output logic [W-1:0] s, output logic co,
                                 output logic ov, output logic z);
    int sa, sb, r, sr;
    sa = (ua >= 8) ? ua - 16 : ua;
    sb = (ub >= 8) ? ub - 16 : ub;
    if (sub) begin
      r  = ua - ub;
      co = (ua >= ub);
      sr = sa - sb;
    end else begin
      r  = ua + ub;
      co = (r >= 16);
      sr = sa + sb;
    end
    s  = W'((r % 16 + 16) % 16);
    ov = (sr > 7) || (sr < -8);
    z  = (s == 0);
  endfunction

  // One clock: update expected state from what was driven, then settle past the edge.
  task automatic cyc();
    logic [W-1:0] s;
    logic co, ov, z;
    @(posedge clk);
    if (rst) begin
      e_sum = '0; e_cout = 0; e_vld = 0; e_ovf = 0; e_zero = 0;
    end else begin
      e_vld = bus.in_valid;
      if (bus.in_valid) begin
        ref_op(int'(bus.a), int'(bus.b), bus.cin, s, co, ov, z);
        e_sum = s; e_cout = co; e_ovf = ov; e_zero = z;
      end
    end
    #1;
  endtask

  task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic c, input logic v);
    bus.a = a; bus.b = b; bus.cin = c; bus.in_valid = v;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      drive(W'($urandom), W'($urandom), 1'($urandom), 1'b1);
      cyc();
      nvec++;
      if (bus.sum !== 4'h0 || bus.cout !== 1'b0 || bus.out_valid !== 1'b0) begin
        errs++;
        $display("FAIL reset cyc%0d: got sum=%h cout=%b vld=%b, want 0/0/0",
                 i, bus.sum, bus.cout, bus.out_valid);
      end
`ifdef ADD_SUB_FLAGS_EN
      nvec++;
      if (bus.overflow !== 1'b0 || bus.zero !== 1'b0) begin
        errs++;
        $display("FAIL reset_flags: got ovf=%b zero=%b, want 0/0", bus.overflow, bus.zero);
      end
`endif
    end
    rst = 1'b0;
  endtask

  task automatic test_directed();
    // a, b, cin, expected sum, cout, overflow, zero
    logic [W-1:0] ta[6] = '{4'b0000, 4'b0100, 4'b0110, 4'b0010, 4'b1111, 4'b0101};
    logic [W-1:0] tb[6] = '{4'b1010, 4'b1010, 4'b1000, 4'b1011, 4'b0001, 4'b0101};
    logic         tc[6] = '{1'b0,    1'b0,    1'b1,    1'b1,    1'b0,    1'b1};
    logic [W-1:0] ts[6] = '{4'b1010, 4'b1110, 4'b1110, 4'b0111, 4'b0000, 4'b0000};
    logic         to[6] = '{1'b0,    1'b0,    1'b0,    1'b0,    1'b1,    1'b1};
    logic         tv[6] = '{1'b0,    1'b0,    1'b1,    1'b0,    1'b0,    1'b0};
    logic         tz[6] = '{1'b0,    1'b0,    1'b0,    1'b0,    1'b1,    1'b1};
    for (int i = 0; i < 6; i++) begin
      drive(ta[i], tb[i], tc[i], 1'b1);
      cyc();
      nvec++;
      if (bus.sum !== ts[i] || bus.cout !== to[i] || bus.out_valid !== 1'b1) begin
        errs++;
        $display("FAIL directed[%0d] %b%s%b: got sum=%b cout=%b vld=%b, want sum=%b cout=%b vld=1",
                 i, ta[i], tc[i] ? "-" : "+", tb[i], bus.sum, bus.cout, bus.out_valid, ts[i], to[i]);
      end
`ifdef ADD_SUB_FLAGS_EN
      nvec++;
      if (bus.overflow !== tv[i] || bus.zero !== tz[i]) begin
        errs++;
        $display("FAIL directed_flags[%0d]: got ovf=%b zero=%b, want ovf=%b zero=%b",
                 i, bus.overflow, bus.zero, tv[i], tz[i]);
      end
`endif
    end
    // 0 - 0: no borrow
    drive(4'b0000, 4'b0000, 1'b1, 1'b1);
    cyc();
    nvec++;
    if (bus.sum !== 4'b0000 || bus.cout !== 1'b1) begin
      errs++;
      $display("FAIL zero_minus_zero: got sum=%b cout=%b, want 0000/1", bus.sum, bus.cout);
    end
  endtask

  task automatic test_hold();
    drive(4'b0011, 4'b0100, 1'b0, 1'b1);
    cyc();
    for (int i = 0; i < 3; i++) begin
      drive(W'($urandom), W'($urandom), 1'($urandom), 1'b0);
      cyc();
      nvec++;
      if (bus.sum !== 4'b0111 || bus.cout !== 1'b0 || bus.out_valid !== 1'b0) begin
        errs++;
        $display("FAIL hold cyc%0d: got sum=%b cout=%b vld=%b, want 0111/0/0",
                 i, bus.sum, bus.cout, bus.out_valid);
      end
    end
  endtask

  task automatic test_reset_precedence();
    drive(4'b1001, 4'b1000, 1'b0, 1'b1);
    cyc();
    rst = 1'b1;
    drive(4'b1111, 4'b1111, 1'b0, 1'b1);
    cyc();
    rst = 1'b0;
    nvec++;
    if (bus.sum !== 4'h0 || bus.cout !== 1'b0 || bus.out_valid !== 1'b0) begin
      errs++;
      $display("FAIL reset_precedence: got sum=%b cout=%b vld=%b, want 0000/0/0",
               bus.sum, bus.cout, bus.out_valid);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 300; i++) begin
      drive(W'($urandom), W'($urandom), 1'($urandom), ($urandom_range(0, 3) != 0));
      rst = ($urandom_range(0, 49) == 0);
      cyc();
      nvec++;
      if (bus.sum !== e_sum || bus.cout !== e_cout || bus.out_valid !== e_vld) begin
        errs++;
        $display("FAIL random[%0d]: got sum=%b cout=%b vld=%b, want sum=%b cout=%b vld=%b",
                 i, bus.sum, bus.cout, bus.out_valid, e_sum, e_cout, e_vld);
      end
`ifdef ADD_SUB_FLAGS_EN
      nvec++;
      if (bus.overflow !== e_ovf || bus.zero !== e_zero) begin
        errs++;
        $display("FAIL random_flags[%0d]: got ovf=%b zero=%b, want ovf=%b zero=%b",
                 i, bus.overflow, bus.zero, e_ovf, e_zero);
      end
`endif
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    drive('0, '0, 1'b0, 1'b0);
    @(negedge clk);
    test_reset();
    test_directed();
    test_hold();
    test_reset_precedence();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, errs);
    $finish;
  end
endmodule

// File: doc/adder_subtractor_4b.md
# adder_subtractor_4b

Registered two's-complement adder/subtractor. A single mode input selects `a + b` or `a - b`, and the result and carry/borrow-out are registered on one clock edge. The block serves as the arithmetic leaf for small datapaths and is built as a ripple chain of full-adder cells.

## Interface
Parameters:
- `WIDTH`, default 4: operand and result width in bits; must be at least 2.

Ports (clock and reset first):
- Clocking: one clock; reset is synchronous and active-high.
- `clk`, input, 1: rising-edge clock.
- `rst`, input, 1: synchronous, active-high reset.
- `a`, input, WIDTH: operand A, unsigned or two's complement.
- `b`, input, WIDTH: operand B.
- `cin`, input, 1: mode select, 0 = add, 1 = subtract. It is also the chain carry-in.
- `in_valid`, input, 1: the operands and mode are sampled this cycle.
- `sum`, output, WIDTH: registered result.
- `cout`, output, 1: registered carry-out of the MSB cell.
- `out_valid`, output, 1: `sum` and `cout` hold a new result.

## Operation
- The B path is XORed with `cin`: `b_eff = b ^ {WIDTH{cin}}`.
- The chain computes `{cout, sum} = a + b_eff + cin`, truncated to WIDTH+1 bits.
- Add mode (`cin` = 0): `sum = (a + b) mod 2^WIDTH`. `cout` is the unsigned carry.
- Subtract mode (`cin` = 1): `sum = (a - b) mod 2^WIDTH`. `cout` = 1 when `a >= b` unsigned (no borrow), and 0 when a borrow occurs.
- The combinational result is captured into the output registers only when `in_valid` = 1.
- When `in_valid` = 0, `sum` and `cout` hold their previous values.
- There is no saturation; wrap-around is the defined behaviour.
- Boundaries:
  - `a = b` in subtract mode gives `sum = 0`, `cout = 1`.
  - All-ones + 1 in add mode gives `sum = 0`, `cout = 1`.
  - `0 - 0` gives `sum = 0`, `cout = 1`.

## Timing
- Latency is 1 cycle. Operands sampled at edge N appear on `sum`/`cout` after edge N.
- `out_valid` is registered from `in_valid` with the same 1-cycle latency.
- Throughput is one operation per cycle. There is no backpressure and no stall.
- Reset: on any edge with `rst` = 1, `sum`, `cout` and `out_valid` go to 0 (and the flags, when compiled in).
- Reset overrides `in_valid` on the same edge.
- An operation in flight when reset asserts is discarded.
- Outputs are driven only from registers; there is no combinational path from input to output.

## Configuration
- Macro `ADD_SUB_FLAGS_EN`.
- Defined: adds the registered outputs `overflow` (1 bit) and `zero` (1 bit).
  - `overflow` = carry into MSB XOR carry out of MSB, i.e. the signed result is out of range.
  - `zero` = 1 when the registered `sum` is all zeros.
  - Both outputs share the same latency, enable and reset (value 0) as `sum`.
- Undefined: these ports and registers do not exist; all other behaviour is identical.

## Structure
- Shared package `add_sub_pkg` holds:
  - the `ADD` = 1'b0 and `SUB` = 1'b1 mode constants;
  - the default width constant (4).
- Sub-module `full_adder`: 1-bit cell with inputs `a`, `b`, `cin` and outputs `s`, `cout`. It is instantiated WIDTH times by a generate loop forming the ripple chain.
- The top level contains the XOR stage, the chain, the output registers and the optional flag logic.

## Test plan
WIDTH = 4 throughout; results are checked one cycle after the `in_valid` pulse.
- Reset: hold `rst` = 1 for 2 cycles with random inputs -> `sum` = 0, `cout` = 0, `out_valid` = 0.
- Add: `a`=0000, `b`=1010, `cin`=0 -> `sum`=1010, `cout`=0.
- Add: `a`=0100, `b`=1010, `cin`=0 -> `sum`=1110, `cout`=0.
- Subtract: `a`=0110, `b`=1000, `cin`=1 -> `sum`=1110, `cout`=0, `overflow`=1 (flags build).
- Subtract: `a`=0010, `b`=1011, `cin`=1 -> `sum`=0111, `cout`=0. Then `a`=1111, `b`=0001, `cin`=0 -> `sum`=0000, `cout`=1, `zero`=1 (flags build).
- Hold and reset precedence: `in_valid`=0 with new operands -> outputs unchanged. `rst`=1 together with `in_valid`=1 -> outputs 0.
